nlms_stream_pairer: RTL and testbench
=====================================

// Module: nlms_stream_pairer
//
// PURPOSE
//   Joins the NLMS "main" (desired) and "aux" (reference) sample streams into
//   lock-step sample pairs for the adaptive-filter core, between the NoC-shell
//   data outputs and the NLMS datapath.
//   Enforces packet alignment: on a tlast mismatch it terminates the output
//   packet and discards the lagging stream up to its tlast, so the core never
//   sees skewed pairs.
//   Provides enable gating at packet boundaries and saturating statistics.
//
// PARAMETERS
//   ITEM_W  32  sample width per stream (sc16 = 32)
//   CNT_W   16  width of statistics counters
//
// PORTS
//   ce_clk          in   1         block clock (all logic)
//   ce_rst_n        in   1         asynchronous active-low reset
//   cfg_enable      in   1         1 = pair traffic; 0 = stop at next packet boundary
//   cfg_clear       in   1         1-cycle pulse: zero stat counters
//   s_main_tdata    in   ITEM_W    desired-signal sample
//   s_main_tlast    in   1         end of main packet
//   s_main_tvalid   in   1         main valid
//   s_main_tready   out  1         main ready
//   s_aux_tdata     in   ITEM_W    reference-signal sample
//   s_aux_tlast     in   1         end of aux packet
//   s_aux_tvalid    in   1         aux valid
//   s_aux_tready    out  1         aux ready
//   m_pair_tdata    out  2*ITEM_W  {aux, main}; main in [ITEM_W-1:0]
//   m_pair_tlast    out  1         end of output packet
//   m_pair_tvalid   out  1         pair valid
//   m_pair_tready   in   1         core ready
//   stat_pairs      out  CNT_W     pairs emitted (saturating)
//   stat_misalign   out  CNT_W     tlast-mismatch events (saturating)
//   misalign_pulse  out  1         1-cycle pulse per mismatch event
//   busy            out  1         state != IDLE or m_pair_tvalid
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, in_pkt=0; all outputs 0.
//   - Output stage: single registered slot.
//     - load_ok = !m_pair_tvalid | m_pair_tready.
//     - Latency: input accept -> m_pair_tvalid next cycle.
//     - Full throughput: 1 pair/cycle.
//   - FSM states:
//     - IDLE: both treadys 0.
//       -> RUN when cfg_enable=1.
//     - RUN: join = s_main_tvalid & s_aux_tvalid & load_ok.
//       - s_main_tready = s_aux_tready = join. No single-sided acceptance.
//       - On join: load {aux,main}; m_pair_tlast = main.tlast | aux.tlast.
//       - in_pkt <= !(main.tlast | aux.tlast).
//       - main.tlast & !aux.tlast -> DRAIN_AUX.
//       - aux.tlast & !main.tlast -> DRAIN_MAIN.
//       - Either mismatch: misalign_pulse=1 next cycle, stat_misalign+1.
//       - cfg_enable=0 with in_pkt=0 and no join this cycle -> IDLE.
//       - cfg_enable=0 mid-packet: continue until the packet ends, then -> IDLE.
//     - DRAIN_MAIN / DRAIN_AUX:
//       - Draining stream's tready=1, independent of m_pair_tready.
//       - Other stream's tready=0. Nothing is emitted.
//       - On the draining stream's tlast beat: -> RUN if cfg_enable else IDLE;
//         in_pkt=0.
//   - Counters:
//     - stat_pairs increments on each join.
//     - Both counters saturate at 2^CNT_W-1 (no wrap).
//     - cfg_clear wins over a same-cycle increment (result 0).
//   - Output slot retains data/valid while m_pair_tready=0. tdata is stable
//     under backpressure (AXIS rule). The slot drains normally in IDLE/DRAIN.
//   - Reset mid-packet drops the slot contents and in_pkt; no recovery beats
//     are emitted.
//
// TESTING
//   1. Aligned: 4-beat packets on both streams, ready=1 -> 4 pairs, tlast on
//      the 4th, 1-cycle latency, stat_pairs=4.
//   2. Main short: main 2 beats, aux 5 beats (then aligned 3/3) -> pair 2 has
//      tlast=1; aux beats 3-5 dropped; stat_misalign=1; the next packet pairs
//      correctly.
//   3. Backpressure: m_pair_tready toggles 1010.. -> no loss or duplication;
//      tdata stable while stalled; s_*_tready=0 while the slot is full and not
//      draining.
//   4. Enable drop mid-packet: cfg_enable=0 at beat 2 of 4 -> beats 3-4 still
//      emitted, then IDLE; treadys 0; busy falls after the last handshake.
//   5. Saturation/clear: CNT_W=4, 20 pairs -> stat_pairs=15. cfg_clear
//      concurrent with a join -> 0.
//   6. Async reset asserted mid-packet -> all outputs 0 immediately. After
//      release, a new aligned packet pairs from beat 1.

Source files
------------

// File: rtl/nlms_stream_pairer.sv
// Joins the NLMS main (desired) and aux (reference) streams into lock-step pairs,
// realigning on tlast mismatches and keeping saturating pair/misalignment counts.
module nlms_stream_pairer #(
  parameter int ITEM_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                ce_clk,
  input  logic                ce_rst_n,
  input  logic                cfg_enable,
  input  logic                cfg_clear,
  input  logic [ITEM_W-1:0]   s_main_tdata,
  input  logic                s_main_tlast,
  input  logic                s_main_tvalid,
  output logic                s_main_tready,
  input  logic [ITEM_W-1:0]   s_aux_tdata,
  input  logic                s_aux_tlast,
  input  logic                s_aux_tvalid,
  output logic                s_aux_tready,
  output logic [2*ITEM_W-1:0] m_pair_tdata,
  output logic                m_pair_tlast,
  output logic                m_pair_tvalid,
  input  logic                m_pair_tready,
  output logic [CNT_W-1:0]    stat_pairs,
  output logic [CNT_W-1:0]    stat_misalign,
  output logic                misalign_pulse,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN_MAIN, DRAIN_AUX} state_t;

  state_t state;
  logic   in_pkt;
  logic   load_ok;
  logic   join_p0;
  logic   mis_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign load_ok = !m_pair_tvalid || m_pair_tready;
  assign join_p0 = (state == RUN) && s_main_tvalid && s_aux_tvalid && load_ok;
  assign mis_p0  = join_p0 && (s_main_tlast ^ s_aux_tlast);
  assign busy    = (state != IDLE) || m_pair_tvalid;

  // Draining discards the lagging stream without waiting for the output slot.
  always_comb begin
    s_main_tready = 1'b0;
    s_aux_tready  = 1'b0;
    case (state)
      RUN: begin
        s_main_tready = join_p0;
        s_aux_tready  = join_p0;
      end
      DRAIN_MAIN: s_main_tready = 1'b1;
      DRAIN_AUX:  s_aux_tready  = 1'b1;
      default: ;
    endcase
  end

  // Stage p0 -> output slot
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      m_pair_tvalid <= 1'b0;
      m_pair_tdata  <= '0;
      m_pair_tlast  <= 1'b0;
    end else if (join_p0) begin
      m_pair_tvalid <= 1'b1;
      m_pair_tdata  <= {s_aux_tdata, s_main_tdata};
      m_pair_tlast  <= s_main_tlast | s_aux_tlast;
    end else if (m_pair_tready) begin
      m_pair_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state          <= IDLE;
      in_pkt         <= 1'b0;
      misalign_pulse <= 1'b0;
    end else begin
      misalign_pulse <= 1'b0;
      case (state)
        IDLE: if (cfg_enable) state <= RUN;
        RUN: begin
          if (join_p0) begin
            in_pkt <= !(s_main_tlast | s_aux_tlast);
            if (s_main_tlast && !s_aux_tlast) begin
              state          <= DRAIN_AUX;
              misalign_pulse <= 1'b1;
            end else if (s_aux_tlast && !s_main_tlast) begin
              state          <= DRAIN_MAIN;
              misalign_pulse <= 1'b1;
            end else if (s_main_tlast && !cfg_enable) begin
              state <= IDLE;
            end
          end else if (!cfg_enable && !in_pkt) begin
            state <= IDLE;
          end
        end
        DRAIN_MAIN: if (s_main_tvalid && s_main_tlast) begin
          state  <= cfg_enable ? RUN : IDLE;
          in_pkt <= 1'b0;
        end
        DRAIN_AUX: if (s_aux_tvalid && s_aux_tlast) begin
          state  <= cfg_enable ? RUN : IDLE;
          in_pkt <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      stat_pairs    <= '0;
      stat_misalign <= '0;
    end else if (cfg_clear) begin
      stat_pairs    <= '0;
      stat_misalign <= '0;
    end else begin
      if (join_p0) stat_pairs    <= sat_inc(stat_pairs);
      if (mis_p0)  stat_misalign <= sat_inc(stat_misalign);
    end
  end

endmodule

// File: tb/tb_nlms_stream_pairer.sv
// Randomized bench for nlms_stream_pairer: a packet-level model pairs packet k of
// each stream over the shorter length and counts length mismatches.
module tb_nlms_stream_pairer;
  localparam int ITEM_W = 32;
  localparam int CNT_W  = 4;
  localparam int SAT    = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_enable, cfg_clear;
  logic [ITEM_W-1:0] s_main_tdata, s_aux_tdata;
  logic              s_main_tlast, s_main_tvalid, s_main_tready;
  logic              s_aux_tlast, s_aux_tvalid, s_aux_tready;
  logic [63:0]       m_pair_tdata;
  logic              m_pair_tlast, m_pair_tvalid, m_pair_tready;
  logic [CNT_W-1:0]  stat_pairs, stat_misalign;
  logic              misalign_pulse, busy;

  always #5 clk = ~clk;

  nlms_stream_pairer #(.ITEM_W(ITEM_W), .CNT_W(CNT_W)) dut (
    .ce_clk(clk), .ce_rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .s_main_tdata(s_main_tdata), .s_main_tlast(s_main_tlast),
    .s_main_tvalid(s_main_tvalid), .s_main_tready(s_main_tready),
    .s_aux_tdata(s_aux_tdata), .s_aux_tlast(s_aux_tlast),
    .s_aux_tvalid(s_aux_tvalid), .s_aux_tready(s_aux_tready),
    .m_pair_tdata(m_pair_tdata), .m_pair_tlast(m_pair_tlast),
    .m_pair_tvalid(m_pair_tvalid), .m_pair_tready(m_pair_tready),
    .stat_pairs(stat_pairs), .stat_misalign(stat_misalign),
    .misalign_pulse(misalign_pulse), .busy(busy)
  );

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [63:0] d; logic l; } pair_t;

  beat_t mq[$];
  beat_t aq[$];
  pair_t eq[$];
  int    exp_mis = 0;
  int    checks  = 0;
  int    errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic add_pkt(input int lm, input int la);
    int mb, ab, n;
    beat_t b;
    pair_t p;
    mb = mq.size();
    ab = aq.size();
    n  = (lm < la) ? lm : la;
    for (int i = 0; i < lm; i++) begin b.d = $urandom; b.l = (i == lm-1); mq.push_back(b); end
    for (int i = 0; i < la; i++) begin b.d = $urandom; b.l = (i == la-1); aq.push_back(b); end
    for (int i = 0; i < n; i++) begin
      p.d = {aq[ab+i].d, mq[mb+i].d};
      p.l = (i == n-1);
      eq.push_back(p);
    end
    if (lm != la) exp_mis++;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 cfg_clear = 1'b1;
    @(posedge clk); #1 cfg_clear = 1'b0;
  endtask

  task automatic idle_inputs();
    s_main_tvalid = 1'b0; s_aux_tvalid = 1'b0;
    s_main_tlast  = 1'b0; s_aux_tlast  = 1'b0;
  endtask

  // rmode: 0 ready always, 1 ready toggles, 2 ready random
  task automatic run_traffic(input int vprob, input int rmode, input int budget);
    int mi, ai, cyc, npairs, nmis, seen_mis;
    bit mfire, afire, stalled;
    logic [63:0] held;
    mi = 0; ai = 0; cyc = 0; seen_mis = 0; stalled = 0; held = '0;
    npairs = eq.size();
    nmis   = exp_mis;
    pulse_clear();
    while ((eq.size() > 0 || mi < mq.size() || ai < aq.size()) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_valid", m_pair_tvalid, 1'b1);
        chk("stall_data", m_pair_tdata, held);
      end
      stalled = m_pair_tvalid && !m_pair_tready;
      held    = m_pair_tdata;
      if (stalled) chk("join_blocked", s_main_tready & s_aux_tready, 1'b0);
      if (m_pair_tvalid && m_pair_tready) begin
        if (eq.size() == 0) chk("extra_pair", m_pair_tvalid, 1'b0);
        else begin
          chk("pair_data", m_pair_tdata, eq[0].d);
          chk("pair_last", m_pair_tlast, eq[0].l);
          void'(eq.pop_front());
        end
      end
      if (misalign_pulse) seen_mis++;
      mfire = s_main_tvalid && s_main_tready;
      afire = s_aux_tvalid && s_aux_tready;
      @(posedge clk); #1;
      if (mfire) mi++;
      if (afire) ai++;
      if (!s_main_tvalid || mfire)
        s_main_tvalid = (mi < mq.size()) && ($urandom_range(99) < vprob);
      if (mi < mq.size()) begin s_main_tdata = mq[mi].d; s_main_tlast = mq[mi].l; end
      if (!s_aux_tvalid || afire)
        s_aux_tvalid = (ai < aq.size()) && ($urandom_range(99) < vprob);
      if (ai < aq.size()) begin s_aux_tdata = aq[ai].d; s_aux_tlast = aq[ai].l; end
      case (rmode)
        0:       m_pair_tready = 1'b1;
        1:       m_pair_tready = ~m_pair_tready;
        default: m_pair_tready = 1'($urandom_range(1));
      endcase
    end
    chk("traffic_pairs_left", eq.size(), 0);
    chk("traffic_main_left", mq.size() - mi, 0);
    chk("traffic_aux_left", aq.size() - ai, 0);
    idle_inputs();
    m_pair_tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (misalign_pulse) seen_mis++;
      if (m_pair_tvalid) chk("extra_pair_tail", m_pair_tvalid, 1'b0);
    end
    chk("misalign_pulses", seen_mis, nmis);
    chk("stat_pairs", stat_pairs, sat(npairs));
    chk("stat_misalign", stat_misalign, sat(nmis));
    mq.delete(); aq.delete(); eq.delete();
    exp_mis = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, m_pair_tvalid, 1'b0);
    chk({tag, "_tdata"}, m_pair_tdata, 64'h0);
    chk({tag, "_tlast"}, m_pair_tlast, 1'b0);
    chk({tag, "_treadys"}, {s_main_tready, s_aux_tready}, 2'b00);
    chk({tag, "_stats"}, {stat_pairs, stat_misalign}, '0);
    chk({tag, "_pulse_busy"}, {misalign_pulse, busy}, 2'b00);
  endtask

  initial begin
    logic [63:0] prev;
    rst_n = 1'b0; cfg_enable = 1'b1; cfg_clear = 1'b0; m_pair_tready = 1'b1;
    s_main_tdata = '0; s_aux_tdata = '0;
    idle_inputs();
    #12 chk_all_zero("reset");
    #10 rst_n = 1'b1;

    // first-beat latency: accepted on one edge, visible right after it
    @(posedge clk); #1;
    s_main_tdata = 32'h1111_aaaa; s_aux_tdata = 32'h2222_bbbb;
    s_main_tlast = 1'b1; s_aux_tlast = 1'b1;
    s_main_tvalid = 1'b1; s_aux_tvalid = 1'b1;
    @(negedge clk);
    chk("lat_join", {s_main_tready, s_aux_tready}, 2'b11);
    chk("lat_not_yet", m_pair_tvalid, 1'b0);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("lat_valid", m_pair_tvalid, 1'b1);
    chk("lat_data", m_pair_tdata, 64'h2222_bbbb_1111_aaaa);
    chk("lat_last", m_pair_tlast, 1'b1);

    // aligned 4-beat packet
    add_pkt(4, 4);
    run_traffic(100, 0, 200);

    // main short, then aligned
    add_pkt(2, 5); add_pkt(3, 3);
    run_traffic(100, 0, 200);
    add_pkt(5, 2); add_pkt(1, 1);
    run_traffic(80, 2, 300);

    // backpressure 1010..
    add_pkt(4, 4); add_pkt(4, 4); add_pkt(3, 6);
    run_traffic(100, 1, 400);

    // random packet lengths, valids and ready
    for (int k = 0; k < 12; k++) begin
      int lm, la;
      lm = $urandom_range(1, 6);
      la = ($urandom_range(1) == 1) ? lm : $urandom_range(1, 6);
      add_pkt(lm, la);
    end
    run_traffic(70, 2, 2000);

    // enable drop after beat 2 of 4
    m_pair_tready = 1'b1;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      s_main_tdata = $urandom; s_aux_tdata = $urandom;
      s_main_tlast = (i == 3); s_aux_tlast = (i == 3);
      s_main_tvalid = 1'b1; s_aux_tvalid = 1'b1;
      if (i == 2) cfg_enable = 1'b0;
      @(negedge clk);
      chk("en_drop_join", {s_main_tready, s_aux_tready}, 2'b11);
      if (i > 0) chk("en_drop_data", m_pair_tdata, prev);
      prev = {s_aux_tdata, s_main_tdata};
      @(posedge clk); #1;
    end
    s_main_tdata = $urandom; s_aux_tdata = $urandom;
    s_main_tlast = 1'b0; s_aux_tlast = 1'b0;
    @(negedge clk);
    chk("en_drop_last", {m_pair_tvalid, m_pair_tlast, m_pair_tdata}, {2'b11, prev});
    chk("en_drop_busy_hi", busy, 1'b1);
    chk("en_drop_idle_ready", {s_main_tready, s_aux_tready}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_drop_busy_lo", {busy, m_pair_tvalid}, 2'b00);
    chk("en_drop_idle_ready2", {s_main_tready, s_aux_tready}, 2'b00);
    idle_inputs();
    cfg_enable = 1'b1;
    @(posedge clk); #1;

    // clear concurrent with a join; stats are non-zero from the previous run
    s_main_tdata = $urandom; s_aux_tdata = $urandom;
    s_main_tlast = 1'b1; s_aux_tlast = 1'b1;
    s_main_tvalid = 1'b1; s_aux_tvalid = 1'b1;
    cfg_clear = 1'b1;
    @(negedge clk);
    chk("clr_join", {s_main_tready, s_aux_tready}, 2'b11);
    @(posedge clk); #1;
    cfg_clear = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("clr_wins", stat_pairs, 0);
    chk("clr_pair_out", m_pair_tvalid, 1'b1);
    @(posedge clk); #1;

    // 20 pairs saturate a 4-bit counter, plus 17 mismatches
    for (int k = 0; k < 4; k++) add_pkt(5, 5);
    run_traffic(70, 2, 600);
    for (int k = 0; k < 17; k++) add_pkt(1, 2);
    run_traffic(90, 0, 600);

    // async reset mid-packet with the slot stalled
    s_main_tdata = $urandom; s_aux_tdata = $urandom;
    s_main_tvalid = 1'b1; s_aux_tvalid = 1'b1;
    @(posedge clk); #1;
    s_main_tdata = $urandom; s_aux_tdata = $urandom;
    m_pair_tready = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    idle_inputs();
    #2 rst_n = 1'b1;
    m_pair_tready = 1'b1;
    add_pkt(4, 4);
    run_traffic(100, 0, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
